// File: rtl/level_shifter_sweep_ctrl.sv
// Up/down VIN code sweep sequencer for level-shifter characterisation.
// Samples VOUT at the end of each settle window and records switching thresholds.
module level_shifter_sweep_ctrl #(
   parameter int CODE_W     = 12,
   parameter int START_CODE = -1000,
   parameter int END_CODE   = 1000,
   parameter int STEP       = 10,
   parameter int SETTLE_CYC = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     vout_bit,
   output logic signed [CODE_W-1:0] vin_code,
   output logic                     vin_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     rise_found,
   output logic                     fall_found,
   output logic signed [CODE_W-1:0] th_rise,
   output logic signed [CODE_W-1:0] th_fall,
   output logic signed [CODE_W-1:0] hyst
);

   typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

   localparam int CNT_W = ($clog2(SETTLE_CYC) > 0) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0]         SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
   localparam logic signed [CODE_W-1:0] START_C   = CODE_W'(START_CODE);
   localparam logic signed [CODE_W-1:0] END_C     = CODE_W'(END_CODE);
   localparam logic signed [CODE_W:0]   START_X   = (CODE_W+1)'(START_CODE);
   localparam logic signed [CODE_W:0]   END_X     = (CODE_W+1)'(END_CODE);
   localparam logic signed [CODE_W:0]   STEP_X    = (CODE_W+1)'(STEP);

   state_t                     state_q, state_d;
   logic signed [CODE_W-1:0]   code_q, code_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       first_q, first_d;
   logic                       prev_q, prev_d;
   logic                       rise_q, rise_d, fall_q, fall_d;
   logic signed [CODE_W-1:0]   th_rise_q, th_rise_d, th_fall_q, th_fall_d;

   logic signed [CODE_W:0]     code_x, up_x, dn_x;
   logic signed [CODE_W-1:0]   up_code, dn_code;
   logic                       sample;

   // One extra bit keeps the step past either sweep end from wrapping before the clamp.
   assign code_x  = (CODE_W+1)'(code_q);
   assign up_x    = code_x + STEP_X;
   assign dn_x    = code_x - STEP_X;
   assign up_code = (up_x >= END_X)   ? END_C   : up_x[CODE_W-1:0];
   assign dn_code = (dn_x <= START_X) ? START_C : dn_x[CODE_W-1:0];
   assign sample  = (cnt_q == SETTLE_M1);

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      cnt_d     = cnt_q;
      first_d   = first_q;
      prev_d    = prev_q;
      rise_d    = rise_q;
      fall_d    = fall_q;
      th_rise_d = th_rise_q;
      th_fall_d = th_fall_q;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d   = UP;
               code_d    = START_C;
               cnt_d     = '0;
               first_d   = 1'b1;
               rise_d    = 1'b0;
               fall_d    = 1'b0;
               th_rise_d = '0;
               th_fall_d = '0;
            end
         end
         UP, DOWN: begin
            if (abort) begin
               state_d = IDLE;
               code_d  = '0;
               cnt_d   = '0;
            end else if (!sample) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d   = '0;
               first_d = 1'b0;
               prev_d  = vout_bit;
               // Edge check happens before the ramp-end transition on the same sample.
               if (state_q == UP) begin
                  if (!first_q && !rise_q && !prev_q && vout_bit) begin
                     rise_d    = 1'b1;
                     th_rise_d = code_q;
                  end
                  if (code_q == END_C) begin
                     state_d = DOWN;
                     first_d = 1'b1;
                  end else begin
                     code_d = up_code;
                  end
               end else begin
                  if (!first_q && !fall_q && prev_q && !vout_bit) begin
                     fall_d    = 1'b1;
                     th_fall_d = code_q;
                  end
                  if (code_q == START_C) begin
                     state_d = DONE;
                     code_d  = '0;
                  end else begin
                     code_d = dn_code;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         code_q    <= '0;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         prev_q    <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         th_rise_q <= '0;
         th_fall_q <= '0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         prev_q    <= prev_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         th_rise_q <= th_rise_d;
         th_fall_q <= th_fall_d;
      end
   end

   assign busy       = (state_q == UP) || (state_q == DOWN);
   assign vin_valid  = busy;
   assign done       = (state_q == DONE);
   assign vin_code   = code_q;
   assign rise_found = rise_q;
   assign fall_found = fall_q;
   assign th_rise    = th_rise_q;
   assign th_fall    = th_fall_q;
   assign hyst       = (rise_q && fall_q) ? (th_rise_q - th_fall_q) : '0;

endmodule

// File: tb/tb_level_shifter_sweep_ctrl.sv
// Bench for level_shifter_sweep_ctrl: directed table plus random sweeps checked
// against a point-list reference model (default STEP and STEP=30 instances).
module tb_level_shifter_sweep_ctrl;
   localparam int W = 12, S = 10, START = -1000, ENDC = 1000;

   logic clk = 1'b0, rst = 1'b1;
   logic start_a = 0, abort_a = 0, vout_a = 0, start_b = 0, abort_b = 0, vout_b = 0;
   logic signed [W-1:0] code_a, code_b, thr_a, thr_b, thf_a, thf_b, hy_a, hy_b;
   logic vv_a, vv_b, busy_a, busy_b, done_a, done_b, rf_a, rf_b, ff_a, ff_b;
   logic sel = 1'b0;
   logic signed [W-1:0] code_s, thr_s, thf_s, hy_s;
   logic vv_s, busy_s, done_s, rf_s, ff_s;
   int errors = 0, checks = 0;

   int codes[$];
   bit bits[$];
   int n_up;

   always #5 clk = ~clk;

   level_shifter_sweep_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .vout_bit(vout_a),
      .vin_code(code_a), .vin_valid(vv_a), .busy(busy_a), .done(done_a),
      .rise_found(rf_a), .fall_found(ff_a), .th_rise(thr_a), .th_fall(thf_a), .hyst(hy_a));

   level_shifter_sweep_ctrl #(.STEP(30)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .vout_bit(vout_b),
      .vin_code(code_b), .vin_valid(vv_b), .busy(busy_b), .done(done_b),
      .rise_found(rf_b), .fall_found(ff_b), .th_rise(thr_b), .th_fall(thf_b), .hyst(hy_b));

   assign code_s = sel ? code_b : code_a;
   assign thr_s  = sel ? thr_b  : thr_a;
   assign thf_s  = sel ? thf_b  : thf_a;
   assign hy_s   = sel ? hy_b   : hy_a;
   assign vv_s   = sel ? vv_b   : vv_a;
   assign busy_s = sel ? busy_b : busy_a;
   assign done_s = sel ? done_b : done_a;
   assign rf_s   = sel ? rf_b   : rf_a;
   assign ff_s   = sel ? ff_b   : ff_a;

   task automatic chk(input string name, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input bit b, input bit s, input bit a, input bit v);
      if (b) begin start_b = s; abort_b = a; vout_b = v; end
      else   begin start_a = s; abort_a = a; vout_a = v; end
   endtask

   // Reference: explicit list of points for both ramps plus the VOUT bit seen at each.
   task automatic build(input int step, input int mode);
      int c;
      bit up, v;
      codes.delete();
      bits.delete();
      c = START;
      forever begin
         codes.push_back(c);
         if (c == ENDC) break;
         c = (c + step >= ENDC) ? ENDC : c + step;
      end
      n_up = codes.size();
      c = ENDC;
      forever begin
         codes.push_back(c);
         if (c == START) break;
         c = (c - step <= START) ? START : c - step;
      end
      foreach (codes[i]) begin
         up = (i < n_up);
         case (mode)
            0: v = up ? (codes[i] >= 520) : (codes[i] >= 480);
            1: v = 1'b1;
            2: v = up ? (codes[i] >= 520 || codes[i] == 490 || codes[i] == 510) : (codes[i] >= 480);
            default: v = 1'($urandom_range(0, 1));
         endcase
         bits.push_back(v);
      end
   endtask

   task automatic expect_res(input int ns, output bit er, output bit ef, output int tr, output int tf);
      er = 0; ef = 0; tr = 0; tf = 0;
      for (int i = 1; i < n_up && i < ns; i++)
         if (!er && !bits[i-1] && bits[i]) begin er = 1; tr = codes[i]; end
      for (int i = n_up + 1; i < codes.size() && i < ns; i++)
         if (!ef && bits[i-1] && !bits[i]) begin ef = 1; tf = codes[i]; end
   endtask

   // kill: 0 none, 1 abort, 2 reset, asserted during busy cycle kill_at.
   task automatic run(input bit b, input int mode, input int kill, input int kill_at, input bit hold);
      int total, ns, tr, tf, code_err, k;
      bit er, ef, stop;
      sel = b;
      build(b ? 30 : 10, mode);
      total = codes.size() * S;
      ns = codes.size();
      stop = 0;
      code_err = 0;
      @(negedge clk); set_in(b, 1, 0, 0);
      @(negedge clk); set_in(b, hold, 0, 0);
      for (int cyc = 0; cyc < total; cyc++) begin
         k = cyc / S;
         if (cyc > 0) @(negedge clk);
         if ($signed(code_s) != codes[k] || busy_s !== 1'b1 || vv_s !== 1'b1 || done_s !== 1'b0)
            code_err++;
         set_in(b, hold, 0, bits[k]);
         if (kill != 0 && cyc == kill_at) begin
            ns = cyc / S;
            if (kill == 1) set_in(b, hold, 1, bits[k]);
            else rst = 1'b1;
            stop = 1;
            break;
         end
      end
      chk("busy_code_seq", code_err, 0);
      @(negedge clk);
      set_in(b, 0, 0, 0);
      rst = 1'b0;
      chk(stop ? "done_after_kill" : "done_pulse", done_s, stop ? 0 : 1);
      chk("busy_after", busy_s, 0);
      chk("valid_after", vv_s, 0);
      chk("code_after", code_s, 0);
      if (!stop) begin
         @(negedge clk);
         chk("done_one_cycle", done_s, 0);
      end
      expect_res(ns, er, ef, tr, tf);
      if (kill == 2) begin er = 0; ef = 0; tr = 0; tf = 0; end
      chk("rise_found", rf_s, er);
      chk("fall_found", ff_s, ef);
      chk("th_rise", thr_s, tr);
      chk("th_fall", thf_s, tf);
      chk("hyst", hy_s, (er && ef) ? tr - tf : 0);
   endtask

   typedef struct {
      bit b30; int mode; int kill; int kill_at; bit hold;
      bit rf; bit ff; int tr; int tf; int hy;
   } vec_t;

   vec_t tbl[7];

   initial begin
      tbl[0] = '{0, 0, 0, 0,    0, 1, 1, 520, 470, 50};
      tbl[1] = '{1, 0, 0, 0,    0, 1, 1, 530, 460, 70};
      tbl[2] = '{0, 1, 0, 0,    0, 0, 0, 0,   0,   0};
      tbl[3] = '{0, 0, 1, 1500, 0, 0, 0, 0,   0,   0};
      tbl[4] = '{0, 0, 0, 0,    0, 1, 1, 520, 470, 50};
      tbl[5] = '{0, 2, 0, 0,    0, 1, 1, 490, 470, 20};
      tbl[6] = '{0, 0, 2, 3000, 1, 0, 0, 0,   0,   0};

      repeat (3) @(negedge clk);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_code_a", code_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_flags_b", {rf_b, ff_b, vv_b}, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run(tbl[i].b30, tbl[i].mode, tbl[i].kill, tbl[i].kill_at, tbl[i].hold);
         chk($sformatf("tbl%0d_rf", i), rf_s, tbl[i].rf);
         chk($sformatf("tbl%0d_ff", i), ff_s, tbl[i].ff);
         chk($sformatf("tbl%0d_th_rise", i), thr_s, tbl[i].tr);
         chk($sformatf("tbl%0d_th_fall", i), thf_s, tbl[i].tf);
         chk($sformatf("tbl%0d_hyst", i), hy_s, tbl[i].hy);
         if (i == 1) begin
            chk("step30_points", codes.size(), 136);
            chk("step30_up_pre_end", codes[66], 980);
            chk("step30_dn_pre_end", codes[134], -980);
         end
         repeat (2) @(negedge clk);
      end

      for (int r = 0; r < 4; r++) begin
         int b, kl;
         b  = $urandom_range(0, 1);
         kl = ($urandom_range(0, 2) == 0) ? 1 : 0;
         run(1'(b), 3, kl, $urandom_range(0, 1300), 0);
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
